// File: rtl/spi_flash_reader.sv
// SPI flash read engine for the game loader: 4-byte little-endian words, sequential requests continue the open burst.
// Build option FLASH_FAST_READ_EN selects FAST READ (0x0B) with 8 dummy SCK cycles instead of READ (0x03).
module spi_flash_reader #(
  parameter int CLK_DIV  = 2,
  parameter int CS_HIGH  = 4,
  parameter int WAKE_CYC = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [23:0] flash_address,
  output logic [31:0] flash_dout,
  output logic        flashmem_ready,
  output logic        spi_csn,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] SAMPLE = 4'd1;
  localparam logic [3:0] CSHI   = 4'd2;
  localparam logic [3:0] CMD    = 4'd3;
  localparam logic [3:0] ADDR   = 4'd4;
  localparam logic [3:0] DATA   = 4'd6;
  localparam logic [3:0] RDY    = 4'd7;
  localparam logic [3:0] GAP    = 4'd8;
`ifdef FLASH_FAST_READ_EN
  localparam logic [3:0] DUMMY  = 4'd5;
  localparam logic [7:0] READ_CMD = 8'h0B;
`else
  localparam logic [7:0] READ_CMD = 8'h03;
`endif

  localparam int DW = $clog2(2 * CLK_DIV + 1);
  localparam int CW = $clog2(CS_HIGH + 2);
  localparam int WW = $clog2(WAKE_CYC + 2);
  localparam logic [DW-1:0] DIV_RISE = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);

  logic [3:0]    state_reg;
  logic          csn_reg, sck_reg, mosi_reg, ready_reg;
  logic [31:0]   dout_reg;
  logic          burst_open_reg, cont_reg;
  logic [23:0]   next_addr_reg, addr_reg;
  logic [30:0]   tx_reg;
  logic [31:0]   rx_reg;
  logic [DW-1:0] div_cnt_reg;
  logic [4:0]    bit_cnt_reg;
  logic [CW-1:0] cs_cnt_reg;
  logic [WW-1:0] wake_cnt_reg;
  logic          wake_done_reg;

  logic          shifting, last_bit, bit_end;
  logic [23:0]   req_addr;

  assign req_addr = flash_address & 24'hFFFFFE;

  always_comb begin
    shifting = 1'b0;
    last_bit = 1'b0;
    case (state_reg)
      CMD:  begin shifting = 1'b1; last_bit = (bit_cnt_reg == 5'd7);  end
      ADDR: begin shifting = 1'b1; last_bit = (bit_cnt_reg == 5'd23); end
`ifdef FLASH_FAST_READ_EN
      DUMMY: begin shifting = 1'b1; last_bit = (bit_cnt_reg == 5'd7); end
`endif
      DATA: begin shifting = 1'b1; last_bit = (bit_cnt_reg == (cont_reg ? 5'd15 : 5'd31)); end
      default: ;
    endcase
  end

  assign bit_end = shifting && (div_cnt_reg == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      csn_reg        <= 1'b1;
      sck_reg        <= 1'b0;
      mosi_reg       <= 1'b0;
      ready_reg      <= 1'b0;
      dout_reg       <= '0;
      burst_open_reg <= 1'b0;
      cont_reg       <= 1'b0;
      next_addr_reg  <= '0;
      addr_reg       <= '0;
      tx_reg         <= '0;
      rx_reg         <= '0;
      div_cnt_reg    <= '0;
      bit_cnt_reg    <= '0;
      cs_cnt_reg     <= '0;
      wake_cnt_reg   <= '0;
      wake_done_reg  <= (WAKE_CYC == 0);
    end else begin
      ready_reg <= 1'b0;
      if (!wake_done_reg) begin
        wake_cnt_reg <= wake_cnt_reg + WW'(1);
        if (32'(wake_cnt_reg) + 32'd1 >= WAKE_CYC) wake_done_reg <= 1'b1;
      end

      if (!enable) begin
        // Loader stopped: drop the burst, any partial word is discarded.
        state_reg      <= IDLE;
        csn_reg        <= 1'b1;
        sck_reg        <= 1'b0;
        mosi_reg       <= 1'b0;
        burst_open_reg <= 1'b0;
        div_cnt_reg    <= '0;
        bit_cnt_reg    <= '0;
      end else begin
        if (shifting) begin
          if (bit_end) begin
            div_cnt_reg <= '0;
            sck_reg     <= 1'b0;
            bit_cnt_reg <= last_bit ? 5'd0 : bit_cnt_reg + 5'd1;
            // Zeros shift in behind the address, so mosi idles low in dummy/data phases.
            mosi_reg    <= tx_reg[30];
            tx_reg      <= {tx_reg[29:0], 1'b0};
          end else begin
            div_cnt_reg <= div_cnt_reg + DW'(1);
          end
          if (div_cnt_reg == DIV_RISE) begin
            sck_reg <= 1'b1;
            if (state_reg == DATA) rx_reg <= {rx_reg[30:0], spi_miso};
          end
        end

        case (state_reg)
          IDLE: begin
            csn_reg <= 1'b1;
            if (wake_done_reg) state_reg <= SAMPLE;
          end
          SAMPLE: begin
            addr_reg <= req_addr;
            if (burst_open_reg && req_addr == next_addr_reg) begin
              cont_reg  <= 1'b1;
              state_reg <= DATA;
            end else begin
              cont_reg       <= 1'b0;
              burst_open_reg <= 1'b0;
              csn_reg        <= 1'b1;
              cs_cnt_reg     <= '0;
              state_reg      <= CSHI;
            end
          end
          CSHI: begin
            cs_cnt_reg <= cs_cnt_reg + CW'(1);
            if (32'(cs_cnt_reg) + 32'd1 >= CS_HIGH) begin
              csn_reg     <= 1'b0;
              mosi_reg    <= READ_CMD[7];
              tx_reg      <= {READ_CMD[6:0], addr_reg};
              div_cnt_reg <= '0;
              bit_cnt_reg <= '0;
              state_reg   <= CMD;
            end
          end
          CMD:  if (bit_end && last_bit) state_reg <= ADDR;
`ifdef FLASH_FAST_READ_EN
          ADDR:  if (bit_end && last_bit) state_reg <= DUMMY;
          DUMMY: if (bit_end && last_bit) state_reg <= DATA;
`else
          ADDR: if (bit_end && last_bit) state_reg <= DATA;
`endif
          DATA: begin
            if (bit_end && last_bit) begin
              state_reg      <= RDY;
              ready_reg      <= 1'b1;
              burst_open_reg <= 1'b1;
              next_addr_reg  <= addr_reg + 24'd2;
              // Continuation only fetches the two bytes following the previous word.
              dout_reg <= cont_reg ? {rx_reg[7:0], rx_reg[15:8], dout_reg[31:16]}
                                   : {rx_reg[7:0], rx_reg[15:8], rx_reg[23:16], rx_reg[31:24]};
            end
          end
          RDY:     state_reg <= GAP;
          GAP:     state_reg <= SAMPLE;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign flash_dout     = dout_reg;
  assign flashmem_ready = ready_reg;
  assign spi_csn        = csn_reg;
  assign spi_sck        = sck_reg;
  assign spi_mosi       = mosi_reg;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a mode-0 READ flash model (mem[i] = i[7:0] ^ 8'h5A).
module tb_spi_flash_reader;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [23:0] flash_address;
  logic [31:0] flash_dout;
  logic        flashmem_ready, spi_csn, spi_sck, spi_mosi;
  logic        spi_miso = 1'b0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  spi_flash_reader #(.CLK_DIV(2), .CS_HIGH(4), .WAKE_CYC(0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .flash_address(flash_address),
    .flash_dout(flash_dout), .flashmem_ready(flashmem_ready),
    .spi_csn(spi_csn), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  // Flash model: shifts in command+address on sck rise, drives data on sck fall.
  int          mbits = 0;
  int          kbit;
  logic [31:0] shin = '0;
  logic [31:0] cap = '0;
  logic [23:0] base = '0;
  logic [7:0]  bv;
  int          csn_falls = 0;
  int          last_high = 0;
  int          ready_cnt = 0;
  time         t_rise = 0;

  always @(posedge spi_csn) t_rise = $time;
  always @(negedge spi_csn) begin
    mbits = 0;
    csn_falls++;
    last_high = int'(($time - t_rise) / 10);
  end
  always @(posedge spi_sck) begin
    if (spi_csn === 1'b0) begin
      if (mbits < 32) begin
        shin = {shin[30:0], spi_mosi};
        if (mbits == 31) begin
          cap  = shin;
          base = shin[23:0];
        end
      end
      mbits++;
    end
  end
  always @(negedge spi_sck) begin
    if (spi_csn === 1'b0 && mbits >= 32) begin
      kbit = mbits - 32;
      bv = 8'(base + 24'(kbit / 8)) ^ 8'h5A;
      spi_miso = bv[7 - (kbit % 8)];
    end
  end
  always @(posedge clk) if (flashmem_ready === 1'b1) ready_cnt++;

  task automatic wait_ready(input int limit, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (flashmem_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    $display("txn addr=%h dout=%h cycles=%0d ready=%b", flash_address, flash_dout, cyc, ok);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; flash_address = '0;
    repeat (3) @(negedge clk);
    total++; if (spi_csn !== 1'b1) $display("FAIL reset_csn: got %b, expected 1", spi_csn); else passed++;
    total++; if (spi_sck !== 1'b0) $display("FAIL reset_sck: got %b, expected 0", spi_sck); else passed++;
    total++; if (spi_mosi !== 1'b0) $display("FAIL reset_mosi: got %b, expected 0", spi_mosi); else passed++;
    total++; if (flashmem_ready !== 1'b0) $display("FAIL reset_ready: got %b, expected 0", flashmem_ready); else passed++;
    total++; if (flash_dout !== 32'h0) $display("FAIL reset_dout: got %h, expected 00000000", flash_dout); else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cold_read();
    int cyc; bit ok; int f0;
    f0 = csn_falls;
    flash_address = 24'h200000; enable = 1'b1;
    wait_ready(400, cyc, ok);
    total++; if (!ok) $display("FAIL cold_ready: none within %0d cycles, expected a pulse", cyc); else passed++;
    total++; if (cyc !== 262) $display("FAIL cold_latency: got %0d, expected 262", cyc); else passed++;
    total++; if (flash_dout !== 32'h59585B5A) $display("FAIL cold_dout: got %h, expected 59585b5a", flash_dout); else passed++;
    total++; if (cap !== 32'h03200000) $display("FAIL cold_cmd_addr: got %h, expected 03200000", cap); else passed++;
    total++; if (csn_falls - f0 !== 1) $display("FAIL cold_csn_falls: got %0d, expected 1", csn_falls - f0); else passed++;
  endtask

  task automatic test_stream();
    int cyc; bit ok; int f0;
    f0 = csn_falls;
    flash_address = 24'h200002;
    @(negedge clk);
    total++; if (flashmem_ready !== 1'b0) $display("FAIL ready_single_pulse: got %b, expected 0", flashmem_ready); else passed++;
    wait_ready(200, cyc, ok);
    // One cycle already consumed by the pulse-width check above.
    total++; if (!ok || cyc !== 66) $display("FAIL stream2_latency: got %0d (ok=%b), expected 66", cyc, ok); else passed++;
    total++; if (flash_dout !== 32'h5F5E5958) $display("FAIL stream2_dout: got %h, expected 5f5e5958", flash_dout); else passed++;
    flash_address = 24'h200004;
    wait_ready(200, cyc, ok);
    total++; if (!ok || cyc !== 67) $display("FAIL stream3_latency: got %0d (ok=%b), expected 67", cyc, ok); else passed++;
    total++; if (flash_dout !== 32'h5D5C5F5E) $display("FAIL stream3_dout: got %h, expected 5d5c5f5e", flash_dout); else passed++;
    total++; if (csn_falls !== f0) $display("FAIL stream_csn_falls: got %0d, expected %0d", csn_falls, f0); else passed++;
  endtask

  task automatic test_jump();
    int cyc; bit ok; int f0;
    flash_address = 24'h207FC0;
    wait_ready(600, cyc, ok);
    total++; if (!ok) $display("FAIL jump1_ready: none within %0d cycles, expected a pulse", cyc); else passed++;
    total++; if (cap !== 32'h03207FC0) $display("FAIL jump1_cmd_addr: got %h, expected 03207fc0", cap); else passed++;
    f0 = csn_falls;
    flash_address = 24'h20FFC0;
    wait_ready(600, cyc, ok);
    total++; if (!ok) $display("FAIL jump2_ready: none within %0d cycles, expected a pulse", cyc); else passed++;
    total++; if (flash_dout !== 32'h99989B9A) $display("FAIL jump2_dout: got %h, expected 99989b9a", flash_dout); else passed++;
    total++; if (cap !== 32'h0320FFC0) $display("FAIL jump2_cmd_addr: got %h, expected 0320ffc0", cap); else passed++;
    total++; if (csn_falls - f0 !== 1) $display("FAIL jump2_csn_falls: got %0d, expected 1", csn_falls - f0); else passed++;
    total++; if (last_high < 4) $display("FAIL jump2_csn_high: got %0d clk, expected >= 4", last_high); else passed++;
  endtask

  task automatic test_abort();
    int cyc; bit ok; bit saw_high; int r0;
    flash_address = 24'h201010;
    saw_high = 1'b0; ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (spi_csn === 1'b1) saw_high = 1'b1;
      if (saw_high && spi_csn === 1'b0 && mbits >= 12) begin
        ok = 1'b1;
        break;
      end
    end
    total++; if (!ok) $display("FAIL abort_reach_addr: address phase not reached, expected within 400 cycles"); else passed++;
    enable = 1'b0;
    r0 = ready_cnt;
    @(negedge clk);
    total++; if (spi_csn !== 1'b1) $display("FAIL abort_csn: got %b, expected 1", spi_csn); else passed++;
    total++; if (spi_sck !== 1'b0) $display("FAIL abort_sck: got %b, expected 0", spi_sck); else passed++;
    repeat (20) @(negedge clk);
    total++; if (ready_cnt !== r0) $display("FAIL abort_no_ready: got %0d pulses, expected 0", ready_cnt - r0); else passed++;
    enable = 1'b1;
    wait_ready(400, cyc, ok);
    total++; if (!ok || cyc !== 262) $display("FAIL abort_relatency: got %0d (ok=%b), expected 262", cyc, ok); else passed++;
    total++; if (flash_dout !== 32'h49484B4A) $display("FAIL abort_dout: got %h, expected 49484b4a", flash_dout); else passed++;
    total++; if (cap !== 32'h03201010) $display("FAIL abort_cmd_addr: got %h, expected 03201010", cap); else passed++;
  endtask

  task automatic test_wrap();
    int cyc; bit ok; int f0;
    flash_address = 24'hFFFFFC;
    wait_ready(600, cyc, ok);
    total++; if (flash_dout !== 32'hA5A4A7A6) $display("FAIL wrap0_dout: got %h, expected a5a4a7a6", flash_dout); else passed++;
    total++; if (cap !== 32'h03FFFFFC) $display("FAIL wrap0_cmd_addr: got %h, expected 03fffffc", cap); else passed++;
    f0 = csn_falls;
    flash_address = 24'hFFFFFE;
    wait_ready(200, cyc, ok);
    total++; if (!ok || cyc !== 67) $display("FAIL wrap1_latency: got %0d (ok=%b), expected 67", cyc, ok); else passed++;
    total++; if (flash_dout !== 32'h5B5AA5A4) $display("FAIL wrap1_dout: got %h, expected 5b5aa5a4", flash_dout); else passed++;
    flash_address = 24'h000000;
    wait_ready(200, cyc, ok);
    total++; if (!ok || cyc !== 67) $display("FAIL wrap2_latency: got %0d (ok=%b), expected 67", cyc, ok); else passed++;
    total++; if (flash_dout !== 32'h59585B5A) $display("FAIL wrap2_dout: got %h, expected 59585b5a", flash_dout); else passed++;
    total++; if (csn_falls !== f0) $display("FAIL wrap_csn_falls: got %0d, expected %0d", csn_falls, f0); else passed++;
  endtask

  task automatic test_backward_and_ready_abort();
    int cyc; bit ok; int f0;
    f0 = csn_falls;
    // Bit 0 is ignored, so this requests 0x000000 again: a backward step that must reopen the burst.
    flash_address = 24'h000001;
    wait_ready(600, cyc, ok);
    total++; if (!ok) $display("FAIL back_ready: none within %0d cycles, expected a pulse", cyc); else passed++;
    total++; if (flash_dout !== 32'h59585B5A) $display("FAIL back_dout: got %h, expected 59585b5a", flash_dout); else passed++;
    total++; if (cap !== 32'h03000000) $display("FAIL back_cmd_addr: got %h, expected 03000000", cap); else passed++;
    total++; if (csn_falls - f0 !== 1) $display("FAIL back_csn_falls: got %0d, expected 1", csn_falls - f0); else passed++;
    enable = 1'b0;
    @(negedge clk);
    total++; if (spi_csn !== 1'b1) $display("FAIL rdy_abort_csn: got %b, expected 1", spi_csn); else passed++;
    total++; if (flashmem_ready !== 1'b0) $display("FAIL rdy_abort_ready: got %b, expected 0", flashmem_ready); else passed++;
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_stream();
    test_jump();
    test_abort();
    test_wrap();
    test_backward_and_ready_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
